// File: rtl/lsb_mem_responder.sv
// lsb_mem_responder: byte-serial RAM/IO engine for one LSB load/store at a time,
// returning sign-/zero-extended load words.
module lsb_mem_responder #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [6:0] LD_TYPE    = 7'b0000011,
    parameter logic [6:0] ST_TYPE    = 7'b0100011,
    parameter logic [1:0] IO_SEL     = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  lsb_visit_mem,
    input  logic [6:0]            op_type_in,
    input  logic [2:0]            op_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [31:0]           data_in,
    output logic                  cache_welcome_signal,
    output logic                  cache_ready,
    output logic                  is_load,
    output logic [31:0]           data_out,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);
    typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN} state_t;
    state_t state, state_nx;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q, a_cur, mem_a_d;
    logic [31:0]           data_q, d_src, word_q, word_ins, word_d, ext, data_out_d;
    logic [2:0]            cnt, cnt_d, idx, nb;
    logic [2:0]            op_cur;
    logic [1:0]            p;
    logic [7:0]            d_byte, mem_dout_d;
    logic                  is_idle, is_st_mode, is_ld_req, is_st_req, go, stall, issue, fire;
    logic                  ld_done, st_done, sgn;
    logic                  mem_wr_q, mem_wr_d, welcome_d, ready_d, is_load_d;

    assign is_idle    = state == IDLE;
    assign is_ld_req  = op_type_in == LD_TYPE;
    assign is_st_req  = op_type_in == ST_TYPE;
    assign go         = is_idle & lsb_visit_mem & ~clear_in & (is_ld_req | is_st_req);
    assign op_cur     = is_idle ? op_in : op_q;
    assign nb         = op_cur[1:0] == 2'd0 ? 3'd1 : op_cur[1:0] == 2'd1 ? 3'd2 : 3'd4;
    // The accepting edge already issues byte 0, so IDLE works from the live request inputs.
    assign idx        = is_idle ? 3'd0 : cnt;
    assign a_cur      = (is_idle ? addr_in : addr_q) + ADDR_WIDTH'(idx);
    assign d_src      = is_idle ? data_in : data_q;
    assign d_byte     = d_src[8*idx[1:0] +: 8];
    assign is_st_mode = is_idle ? is_st_req : (state == STORE || state == DRAIN);
    assign stall      = is_st_mode & io_buffer_full & (a_cur[17:16] == IO_SEL);
    assign issue      = is_idle ? go : (idx < nb) & ~(state == LOAD & clear_in);
    assign fire       = issue & ~stall;
    assign ld_done    = state == LOAD && cnt == nb + 3'd1;
    assign st_done    = (state == STORE || state == DRAIN) && cnt == nb;
    assign mem_wr     = mem_wr_q & rdy_in;

    // Load bytes arrive two edges after issue; cnt 2..5 maps to byte lanes 0..3.
    assign p = cnt[1:0] - 2'd2;
    always_comb begin
        word_ins = word_q;
        word_ins[8*p +: 8] = mem_din;
    end

    assign sgn = ~op_q[2];
    assign ext = op_q[1:0] == 2'd0 ? {{24{sgn & word_ins[7]}}, word_ins[7:0]} :
                 op_q[1:0] == 2'd1 ? {{16{sgn & word_ins[15]}}, word_ins[15:0]} : word_ins;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= IDLE;
        else if (rdy_in)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? (is_ld_req ? LOAD : STORE) : IDLE;
            LOAD:    state_nx = (clear_in || ld_done) ? IDLE : LOAD;
            STORE:   state_nx = st_done ? IDLE : clear_in ? DRAIN : STORE;
            DRAIN:   state_nx = st_done ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        welcome_d  = go;
        ready_d    = ~clear_in & (ld_done | (state == STORE & st_done));
        is_load_d  = ~clear_in & ld_done;
        mem_wr_d   = fire & is_st_mode;
        mem_a_d    = fire ? a_cur : mem_a;
        mem_dout_d = mem_wr_d ? d_byte : mem_dout;
        cnt_d      = is_idle ? {2'b00, fire} : state == LOAD ? cnt + 3'd1 : cnt + {2'b00, fire};
        word_d     = (state == LOAD && cnt >= 3'd2) ? word_ins : word_q;
        data_out_d = is_load_d ? ext : data_out;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            op_q                 <= '0;
            addr_q               <= '0;
            data_q               <= '0;
            cnt                  <= '0;
            word_q               <= '0;
            mem_a                <= '0;
            mem_dout             <= '0;
            mem_wr_q             <= 1'b0;
            cache_welcome_signal <= 1'b0;
            cache_ready          <= 1'b0;
            is_load              <= 1'b0;
            data_out             <= '0;
        end else if (rdy_in) begin
            if (go) begin
                op_q   <= op_in;
                addr_q <= addr_in;
                data_q <= data_in;
            end
            cnt                  <= cnt_d;
            word_q               <= word_d;
            mem_a                <= mem_a_d;
            mem_dout             <= mem_dout_d;
            mem_wr_q             <= mem_wr_d;
            cache_welcome_signal <= welcome_d;
            cache_ready          <= ready_d;
            is_load              <= is_load_d;
            data_out             <= data_out_d;
        end
    end
endmodule
